// File: rtl/cfg_scan_loader_if.sv
// Handshake, control and scan-chain signals between the configuration
// loader and its environment. The loader connects through the slave modport.
// The driving side (host plus chain) connects through the master modport.
interface cfg_scan_loader_if #(
   parameter int WORDBITS = 16
);
   logic                start_in;
   logic                abort_in;
   logic [WORDBITS-1:0] cfg_in;
   logic                cfgvalid_in;
   logic                cfgready_out;
   logic                sde_out;
   logic                sd_out;
   logic                sd_in;
   logic [WORDBITS-1:0] rdata_out;
   logic                rvalid_out;
   logic                busy_out;
   logic                done_out;
   logic                err_out;

   modport slave (
      input  start_in, abort_in, cfg_in, cfgvalid_in, sd_in,
      output cfgready_out, sde_out, sd_out, rdata_out, rvalid_out,
             busy_out, done_out, err_out
   );

   modport master (
      output start_in, abort_in, cfg_in, cfgvalid_in, sd_in,
      input  cfgready_out, sde_out, sd_out, rdata_out, rvalid_out,
             busy_out, done_out, err_out
   );
endinterface

// File: rtl/cfg_scan_loader.sv
// Serial configuration loader for the filter scan chain.
// Parallel words are accepted over valid/ready and shifted MSB-first into the
// chain head. The old chain contents are captured from the tail and returned
// word by word.
//
// state | meaning
// IDLE  | waiting for start_in; chain held
// LOAD  | ready for next configuration word; chain held
// SHIFT | shifting one word, one bit per cycle, sde_out high
// DONE  | one-cycle completion pulse after the last word
module cfg_scan_loader #(
   parameter int WORDBITS = 16,
   parameter int NWORDS   = 8
) (
   input  logic clk,
   input  logic rst_n,
   cfg_scan_loader_if.slave bus
);
   localparam int BCW = (WORDBITS > 1) ? $clog2(WORDBITS) : 1;
   localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [WORDBITS-1:0] shreg_q, shreg_d;
   logic [WORDBITS-2:0] cap_q, cap_d;
   logic [WORDBITS-1:0] cap_next;
   logic [BCW-1:0]      bitcnt_q, bitcnt_d;
   logic [WCW-1:0]      wordcnt_q, wordcnt_d;
   logic [WORDBITS-1:0] rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                err_q, err_d;

   // State and datapath registers; everything clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         cap_q     <= '0;
         bitcnt_q  <= '0;
         wordcnt_q <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cap_q     <= cap_d;
         bitcnt_q  <= bitcnt_d;
         wordcnt_q <= wordcnt_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic. Abort takes priority over every other event outside IDLE.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cap_d     = cap_q;
      bitcnt_d  = bitcnt_q;
      wordcnt_d = wordcnt_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      err_d     = err_q;
      cap_next  = {cap_q, bus.sd_in};
      case (state_q)
         S_IDLE: begin
            if (bus.start_in && !bus.abort_in) begin
               state_d   = S_LOAD;
               wordcnt_d = '0;
               err_d     = 1'b0;
            end
         end
         S_LOAD: begin
            if (bus.abort_in) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (bus.cfgvalid_in) begin
               shreg_d  = bus.cfg_in;
               bitcnt_d = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bus.abort_in) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               shreg_d = {shreg_q[WORDBITS-2:0], 1'b0};
               cap_d   = cap_next[WORDBITS-2:0];
               if (bitcnt_q == BCW'(WORDBITS - 1)) begin
                  bitcnt_d = '0;
                  rdata_d  = cap_next;
                  rvalid_d = 1'b1;
                  if (wordcnt_q == WCW'(NWORDS - 1)) begin
                     wordcnt_d = '0;
                     state_d   = S_DONE;
                  end else begin
                     wordcnt_d = wordcnt_q + WCW'(1);
                     state_d   = S_LOAD;
                  end
               end else begin
                  bitcnt_d = bitcnt_q + BCW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (bus.abort_in) err_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cfgready_out = (state_q == S_LOAD);
   assign bus.sde_out      = (state_q == S_SHIFT);
   assign bus.sd_out       = (state_q == S_SHIFT) & shreg_q[WORDBITS-1];
   assign bus.busy_out     = (state_q != S_IDLE);
   assign bus.done_out     = (state_q == S_DONE);
   assign bus.rdata_out    = rdata_q;
   assign bus.rvalid_out   = rvalid_q;
   assign bus.err_out      = err_q;
endmodule

// File: tb/tb_cfg_scan_loader.sv
// Testbench for cfg_scan_loader (8-bit words, 2-word chain).
// The chain is modelled as a 16-flop shift register.
// Expected read-back words are queued as loads are issued.
// A negedge monitor pops and compares them on every rvalid_out.
module tb_cfg_scan_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] chain = 16'h0000;
   logic [7:0] exp_q[$];
   int n_total = 0;
   int n_pass = 0;
   int done_cnt = 0;

   cfg_scan_loader_if #(.WORDBITS(8)) ifc ();

   cfg_scan_loader #(.WORDBITS(8), .NWORDS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   // Scan chain: shifts only while scan enable is high.
   always @(posedge clk) if (ifc.sde_out) chain <= {chain[14:0], ifc.sd_out};
   assign ifc.sd_in = chain[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: read-back scoreboard and done pulse tracking.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.done_out) begin
            done_cnt++;
            chk("done_with_rvalid", {31'd0, ifc.rvalid_out}, 32'd1);
         end
         if (ifc.rvalid_out) begin
            if (exp_q.size() == 0) chk("rvalid_unexpected", {31'd0, ifc.rvalid_out}, 32'd0);
            else chk("rdata", {24'd0, ifc.rdata_out}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (!ifc.busy_out) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("idle_wait", {31'd0, ok}, 32'd1);
   endtask

   task automatic do_start();
      wait_idle();
      ifc.start_in = 1'b1;
      @(posedge clk); #1;
      ifc.start_in = 1'b0;
   endtask

   // mode 0: plain, 1: check serial stream, 2: junk inputs during shift,
   // 3: abort after three bits have been shifted
   task automatic send_word(input logic [7:0] w, input int mode, input bit last);
      bit ok = 0;
      ifc.cfg_in = w;
      ifc.cfgvalid_in = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (ifc.cfgready_out) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("accept_wait", {31'd0, ok}, 32'd1);
      chk("sde_in_load", {31'd0, ifc.sde_out}, 32'd0);
      @(posedge clk); #1;
      ifc.cfgvalid_in = 1'b0;
      if (mode == 1) begin
         for (int i = 0; i < 8; i++) begin
            chk("sde_shift", {31'd0, ifc.sde_out}, 32'd1);
            chk("sd_out_bit", {31'd0, ifc.sd_out}, {31'd0, w[7-i]});
            @(posedge clk); #1;
         end
         chk("sde_after", {31'd0, ifc.sde_out}, 32'd0);
         chk("rvalid_latency", {31'd0, ifc.rvalid_out}, 32'd1);
         chk("done_latency", {31'd0, ifc.done_out}, {31'd0, last});
      end else if (mode == 2) begin
         for (int i = 0; i < 8; i++) begin
            chk("busy_in_shift", {31'd0, ifc.busy_out}, 32'd1);
            chk("ready_in_shift", {31'd0, ifc.cfgready_out}, 32'd0);
            ifc.start_in = (i < 6);
            ifc.cfgvalid_in = (i < 6);
            ifc.cfg_in = 8'hEE;
            @(posedge clk); #1;
         end
         ifc.start_in = 1'b0;
         ifc.cfgvalid_in = 1'b0;
      end else if (mode == 3) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
         ifc.abort_in = 1'b1;
         @(posedge clk); #1;
         ifc.abort_in = 1'b0;
         chk("abort_busy", {31'd0, ifc.busy_out}, 32'd0);
         chk("abort_sde", {31'd0, ifc.sde_out}, 32'd0);
         chk("abort_err", {31'd0, ifc.err_out}, 32'd1);
         chk("abort_ready", {31'd0, ifc.cfgready_out}, 32'd0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cfgready"}, {31'd0, ifc.cfgready_out}, 32'd0);
      chk({tag, "_sde"}, {31'd0, ifc.sde_out}, 32'd0);
      chk({tag, "_sd"}, {31'd0, ifc.sd_out}, 32'd0);
      chk({tag, "_rdata"}, {24'd0, ifc.rdata_out}, 32'd0);
      chk({tag, "_rvalid"}, {31'd0, ifc.rvalid_out}, 32'd0);
      chk({tag, "_busy"}, {31'd0, ifc.busy_out}, 32'd0);
      chk({tag, "_done"}, {31'd0, ifc.done_out}, 32'd0);
      chk({tag, "_err"}, {31'd0, ifc.err_out}, 32'd0);
   endtask

   initial begin
      bit ok;
      ifc.start_in = 1'b0;
      ifc.abort_in = 1'b0;
      ifc.cfg_in = 8'h00;
      ifc.cfgvalid_in = 1'b0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Load 1: serial stream check, chain starts all zero.
      do_start();
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      send_word(8'hA5, 1, 1'b0);
      send_word(8'h3C, 1, 1'b1);

      // Load 2: read back load 1.
      do_start();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      send_word(8'h12, 0, 1'b0);
      send_word(8'h34, 0, 1'b1);

      // Load 3: five-cycle valid gap between words.
      do_start();
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      send_word(8'hAB, 0, 1'b0);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (ifc.cfgready_out) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("gap_ready_wait", {31'd0, ok}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("gap_ready", {31'd0, ifc.cfgready_out}, 32'd1);
         chk("gap_sde", {31'd0, ifc.sde_out}, 32'd0);
         @(posedge clk); #1;
      end
      send_word(8'hCD, 0, 1'b1);

      // Load 4: abort after 3 bits of the second word.
      do_start();
      exp_q.push_back(8'hAB);
      send_word(8'h55, 0, 1'b0);
      send_word(8'h66, 3, 1'b0);
      repeat (12) @(posedge clk);
      #1;
      chk("err_sticky", {31'd0, ifc.err_out}, 32'd1);

      // Load 5: start clears err; chain holds 16'h6AAB after the partial shift.
      do_start();
      chk("err_cleared", {31'd0, ifc.err_out}, 32'd0);
      exp_q.push_back(8'h6A); exp_q.push_back(8'hAB);
      send_word(8'h77, 2, 1'b0);
      send_word(8'h88, 0, 1'b1);
      wait_idle();

      // start and abort together in IDLE: abort wins.
      ifc.start_in = 1'b1;
      ifc.abort_in = 1'b1;
      @(posedge clk); #1;
      ifc.start_in = 1'b0;
      ifc.abort_in = 1'b0;
      chk("start_abort_busy", {31'd0, ifc.busy_out}, 32'd0);
      chk("start_abort_err", {31'd0, ifc.err_out}, 32'd0);

      // Reset in the middle of a shift.
      do_start();
      send_word(8'h99, 0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("pre_reset_rdata", {24'd0, ifc.rdata_out}, 32'h0000_00AB);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_busy", {31'd0, ifc.busy_out}, 32'd0);
      chk("post_reset_ready", {31'd0, ifc.cfgready_out}, 32'd0);

      chk("queue_drained", exp_q.size(), 32'd0);
      chk("done_count", done_cnt, 32'd4);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
